// File: rtl/axi_xbar_pkg.sv
// Shared AXI crossbar definitions: response codes and the read-response
// path state encoding.
package axi_xbar_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PASS   = 2'd1,
        RD_DECERR = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axi_rd_skid.sv
// Two-entry ready/valid skid buffer. The output side is fully registered and
// the input ready is registered, so a full-throughput stream is cut in both
// directions at the cost of one cycle of latency.
module axi_rd_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_out_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_out_free;

    assign w_out_free = i_ready || !r_out_valid;
    assign o_ready    = !r_skid_valid && !rst;
    assign o_valid    = r_out_valid;
    assign o_data     = r_out_data;

    // Occupancy of the output register and the overflow (skid) entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid  <= i_valid;
            end
        end else if (i_valid && !r_skid_valid) begin
            r_skid_valid <= 1'b1;
        end
    end

    // Payload movement; the skid entry always drains before new input.
    always_ff @(posedge clk) begin
        if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_data <= r_skid_data;
            end else if (i_valid) begin
                r_out_data <= i_data;
            end
        end else if (i_valid && !r_skid_valid) begin
            r_skid_data <= i_data;
        end
    end

endmodule

// File: rtl/axi_crossbar_rd_resp.sv
// Per-slave-interface read response path: merges the arbitrated upstream R
// stream with locally generated DECERR bursts and reports one completion per
// finished burst.
// Optional macro AXI_CROSSBAR_RD_RESP_OUTREG_EN registers the merged stream
// through a two-entry skid buffer (axi_rd_skid) before m_axi_*.
module axi_crossbar_rd_resp
    import axi_xbar_pkg::*;
#(
    parameter int ID_WIDTH   = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_dec_id,
    input  logic [7:0]            s_dec_len,
    input  logic                  s_dec_valid,
    output logic                  s_dec_ready,
    input  logic [ID_WIDTH-1:0]   s_axi_rid,
    input  logic [DATA_WIDTH-1:0] s_axi_rdata,
    input  logic [1:0]            s_axi_rresp,
    input  logic                  s_axi_rlast,
    input  logic                  s_axi_rvalid,
    output logic                  s_axi_rready,
    output logic [ID_WIDTH-1:0]   m_axi_rid,
    output logic [DATA_WIDTH-1:0] m_axi_rdata,
    output logic [1:0]            m_axi_rresp,
    output logic                  m_axi_rlast,
    output logic                  m_axi_rvalid,
    input  logic                  m_axi_rready,
    output logic [ID_WIDTH-1:0]   m_cpl_id,
    output logic                  m_cpl_valid
);

    rd_state_e             r_state;
    logic                  r_grant_dec;  // 1: DECERR wins a tie, 0: upstream wins
    logic [7:0]            r_cnt;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_cpl_valid;
    logic [ID_WIDTH-1:0]   r_cpl_id;

    logic                  w_sel_up;
    logic                  w_sel_dec;
    logic                  w_fwd_up;
    logic [ID_WIDTH-1:0]   w_rid;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [1:0]            w_rresp;
    logic                  w_rlast;
    logic                  w_rvalid;
    logic                  w_rready;
    logic                  w_hs;
    logic                  w_out_hs_last;

    // Source selection in IDLE: a lone requester wins, a tie goes to the grant bit.
    always_comb begin
        w_sel_up  = 1'b0;
        w_sel_dec = 1'b0;
        if (r_state == RD_IDLE) begin
            if (s_axi_rvalid && s_dec_valid) begin
                w_sel_dec = r_grant_dec;
                w_sel_up  = !r_grant_dec;
            end else begin
                w_sel_up  = s_axi_rvalid;
                w_sel_dec = s_dec_valid;
            end
        end
        w_fwd_up = w_sel_up || (r_state == RD_PASS);
    end

    // Merged R beat: upstream passthrough or a synthesised DECERR beat.
    always_comb begin
        w_rid    = '0;
        w_rdata  = '0;
        w_rresp  = RESP_OKAY;
        w_rlast  = 1'b0;
        w_rvalid = 1'b0;
        if (w_fwd_up) begin
            w_rid    = s_axi_rid;
            w_rdata  = s_axi_rdata;
            w_rresp  = s_axi_rresp;
            w_rlast  = s_axi_rlast;
            w_rvalid = s_axi_rvalid && !rst;
        end else if (r_state == RD_DECERR) begin
            w_rid    = r_id;
            w_rdata  = '0;
            w_rresp  = RESP_DECERR;
            w_rlast  = (r_cnt == 8'd0);
            w_rvalid = !rst;
        end
    end

    assign w_hs         = w_rvalid && w_rready;
    assign s_axi_rready = w_fwd_up && w_rready && !rst;
    assign s_dec_ready  = w_sel_dec && !rst;

`ifdef AXI_CROSSBAR_RD_RESP_OUTREG_EN
    localparam int PW = ID_WIDTH + DATA_WIDTH + 3;

    logic [PW-1:0] w_skid_data;

    axi_rd_skid #(
        .WIDTH (PW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rvalid),
        .o_ready (w_rready),
        .i_data  ({w_rid, w_rdata, w_rresp, w_rlast}),
        .o_valid (m_axi_rvalid),
        .i_ready (m_axi_rready),
        .o_data  (w_skid_data)
    );

    assign {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast} = w_skid_data;
`else
    assign m_axi_rid    = w_rid;
    assign m_axi_rdata  = w_rdata;
    assign m_axi_rresp  = w_rresp;
    assign m_axi_rlast  = w_rlast;
    assign m_axi_rvalid = w_rvalid;
    assign w_rready     = m_axi_rready;
`endif

    assign w_out_hs_last = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    // Burst sequencing. An upstream beat that stalls in IDLE moves to PASS so
    // a late DECERR request cannot pull the already-presented beat away.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RD_IDLE;
            r_grant_dec <= 1'b0;
            r_cnt       <= 8'd0;
            r_id        <= '0;
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (w_sel_dec) begin
                        r_id    <= s_dec_id;
                        r_cnt   <= s_dec_len;
                        r_state <= RD_DECERR;
                    end else if (w_sel_up) begin
                        if (w_hs && w_rlast) begin
                            if (s_dec_valid) r_grant_dec <= 1'b1;
                        end else begin
                            r_state <= RD_PASS;
                        end
                    end
                end
                RD_PASS: begin
                    if (w_hs && w_rlast) begin
                        r_state <= RD_IDLE;
                        if (s_dec_valid) r_grant_dec <= 1'b1;
                    end
                end
                RD_DECERR: begin
                    if (w_hs) begin
                        if (r_cnt == 8'd0) begin
                            r_state <= RD_IDLE;
                            if (s_axi_rvalid) r_grant_dec <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                default: r_state <= RD_IDLE;
            endcase
        end
    end

    // One-cycle completion pulse after every last-beat handshake downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpl_valid <= 1'b0;
            r_cpl_id    <= '0;
        end else begin
            r_cpl_valid <= w_out_hs_last;
            r_cpl_id    <= m_axi_rid;
        end
    end

    assign m_cpl_valid = r_cpl_valid;
    assign m_cpl_id    = r_cpl_id;

endmodule

// File: tb/tb_axi_crossbar_rd_resp.sv
// Scoreboard bench for axi_crossbar_rd_resp: drivers consume stimulus queues,
// expected beats and completions are queued in arrival order, and a monitor
// checks everything the DUT presents.
module tb_axi_crossbar_rd_resp;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] len;
    } dec_t;

    logic        clk;
    logic        rst;
    logic [7:0]  s_dec_id;
    logic [7:0]  s_dec_len;
    logic        s_dec_valid;
    logic        s_dec_ready;
    logic [7:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [7:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [7:0]  m_cpl_id;
    logic        m_cpl_valid;

    beat_t      up_q[$];
    dec_t       dec_q[$];
    beat_t      exp_q[$];
    logic [7:0] cpl_q[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  hs_count = 0;
    bit  rr_random = 0;

    axi_crossbar_rd_resp #(
        .ID_WIDTH   (8),
        .DATA_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_dec_id     (s_dec_id),
        .s_dec_len    (s_dec_len),
        .s_dec_valid  (s_dec_valid),
        .s_dec_ready  (s_dec_ready),
        .s_axi_rid    (s_axi_rid),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rlast  (s_axi_rlast),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .m_axi_rid    (m_axi_rid),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .m_cpl_id     (m_cpl_id),
        .m_cpl_valid  (m_cpl_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an upstream burst is forwarded unchanged and completes once.
    task automatic add_up(input logic [7:0] id, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.id   = id;
            b.data = $urandom;
            b.resp = 2'($urandom_range(0, 3));
            b.last = (k == n - 1);
            up_q.push_back(b);
            exp_q.push_back(b);
        end
        cpl_q.push_back(id);
    endtask

    // Reference model: a failed-decode read becomes len+1 DECERR beats, data zero.
    task automatic add_dec(input logic [7:0] id, input logic [7:0] len);
        beat_t b;
        dec_t  d;
        d.id = id;
        d.len = len;
        dec_q.push_back(d);
        for (int k = 0; k <= int'(len); k++) begin
            b.id   = id;
            b.data = 32'h0;
            b.resp = 2'b11;
            b.last = (k == int'(len));
            exp_q.push_back(b);
        end
        cpl_q.push_back(id);
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while ((up_q.size() + dec_q.size() + exp_q.size() + cpl_q.size()) != 0 && cyc < 3000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 3000) begin
            chk("drain_timeout", 64'(exp_q.size() + cpl_q.size()), 64'd0);
            up_q.delete();
            dec_q.delete();
            exp_q.delete();
            cpl_q.delete();
        end
        @(negedge clk);
    endtask

    // Upstream R driver.
    initial begin : up_drv
        bit    hs;
        beat_t b;
        s_axi_rvalid = 1'b0;
        s_axi_rid    = '0;
        s_axi_rdata  = '0;
        s_axi_rresp  = '0;
        s_axi_rlast  = 1'b0;
        forever begin
            @(negedge clk);
            hs = s_axi_rvalid && s_axi_rready;
            @(posedge clk);
            #1;
            if (hs && up_q.size() > 0) void'(up_q.pop_front());
            if (up_q.size() > 0) begin
                b = up_q[0];
                s_axi_rvalid = 1'b1;
                s_axi_rid    = b.id;
                s_axi_rdata  = b.data;
                s_axi_rresp  = b.resp;
                s_axi_rlast  = b.last;
            end else begin
                s_axi_rvalid = 1'b0;
            end
        end
    end

    // DECERR command driver; also checks the ready pulse width and first-beat latency.
    initial begin : dec_drv
        bit   hs;
        bit   prev_hs;
        dec_t d;
        s_dec_valid = 1'b0;
        s_dec_id    = '0;
        s_dec_len   = '0;
        prev_hs     = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_hs && !rst) begin
                chk("dec_ready_pulse", 64'(s_dec_ready), 64'd0);
`ifndef AXI_CROSSBAR_RD_RESP_OUTREG_EN
                chk("dec_first_beat", 64'(m_axi_rvalid), 64'd1);
`endif
            end
            hs = s_dec_valid && s_dec_ready;
            prev_hs = hs;
            @(posedge clk);
            #1;
            if (hs && dec_q.size() > 0) void'(dec_q.pop_front());
            if (dec_q.size() > 0) begin
                d = dec_q[0];
                s_dec_valid = 1'b1;
                s_dec_id    = d.id;
                s_dec_len   = d.len;
            end else begin
                s_dec_valid = 1'b0;
            end
        end
    end

    // Downstream ready: always high or random per phase.
    initial begin : rr_drv
        m_axi_rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_axi_rready = rr_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: beats, completions, stall stability.
    initial begin : mon
        bit          prev_last;
        bit          prev_stall;
        logic [42:0] prev_pl;
        logic [42:0] cur_pl;
        beat_t       e;
        prev_last  = 1'b0;
        prev_stall = 1'b0;
        prev_pl    = '0;
        forever begin
            @(negedge clk);
            cur_pl = {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast};
            if (rst) begin
                prev_last  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (m_cpl_valid || prev_last) begin
                    chk("cpl_timing", 64'(m_cpl_valid), 64'(prev_last));
                    if (m_cpl_valid) begin
                        if (cpl_q.size() == 0) chk("cpl_unexpected", 64'(m_cpl_id), 64'hFFFF);
                        else chk("cpl_id", 64'(m_cpl_id), 64'(cpl_q.pop_front()));
                    end
                end
                if (prev_stall)
                    chk("stall_stable", {20'd0, m_axi_rvalid, cur_pl}, {20'd0, 1'b1, prev_pl});
`ifndef AXI_CROSSBAR_RD_RESP_OUTREG_EN
                if (s_axi_rvalid && s_axi_rready)
                    chk("up_zero_latency", {23'd0, m_axi_rvalid, m_axi_rid, m_axi_rdata},
                        {23'd0, 1'b1, s_axi_rid, s_axi_rdata});
`endif
                if (m_axi_rvalid && m_axi_rready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        chk("beat_unexpected", 64'(cur_pl), 64'h7FF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 64'(cur_pl), 64'(e));
                    end
                end
                prev_last  = m_axi_rvalid && m_axi_rready && m_axi_rlast;
                prev_stall = m_axi_rvalid && !m_axi_rready;
                prev_pl    = cur_pl;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Phase sequencer.
    initial begin : main
        int base;
        int cyc;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_rvalid", 64'(m_axi_rvalid), 64'd0);
        chk("rst_s_rready", 64'(s_axi_rready), 64'd0);
        chk("rst_dec_ready", 64'(s_dec_ready), 64'd0);
        chk("rst_cpl_valid", 64'(m_cpl_valid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Upstream 4-beat burst, id 0x05.
        rr_random = 1'b0;
        add_up(8'h05, 4);
        wait_drain();

        // DECERR id 0x3A, len 2.
        add_dec(8'h3A, 8'd2);
        wait_drain();

        // Length boundaries.
        add_dec(8'h11, 8'd0);
        wait_drain();
        add_dec(8'h12, 8'd255);
        wait_drain();

        // Both sources pending: bursts strictly alternate, upstream first.
        rr_random = 1'b1;
        for (int i = 0; i < 6; i++) begin
            add_up(8'($urandom_range(0, 255)), 2);
            add_dec(8'($urandom_range(0, 255)), 8'($urandom_range(0, 3)));
        end
        wait_drain();

        // DECERR len 7 under random backpressure.
        add_dec(8'h77, 8'd7);
        wait_drain();

        // Random single-source bursts.
        for (int i = 0; i < 16; i++) begin
            rr_random = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) add_up(8'($urandom_range(0, 255)), $urandom_range(1, 4));
            else add_dec(8'($urandom_range(0, 255)), 8'($urandom_range(0, 5)));
            wait_drain();
        end

        // Reset after beat 2 of a 4-beat DECERR burst.
        rr_random = 1'b0;
        base = hs_count;
        begin
            dec_t d;
            beat_t b;
            d.id = 8'h44;
            d.len = 8'd3;
            dec_q.push_back(d);
            b.id = 8'h44;
            b.data = 32'h0;
            b.resp = 2'b11;
            b.last = 1'b0;
            exp_q.push_back(b);
            exp_q.push_back(b);
        end
        cyc = 0;
        while (hs_count < base + 2 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("rst_mid_beats", 64'(hs_count - base), 64'd2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rvalid", 64'(m_axi_rvalid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalid", 64'(m_axi_rvalid), 64'd0);
        chk("post_rst_cpl", 64'(m_cpl_valid), 64'd0);
        chk("post_rst_exp_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        dec_q.delete();
        add_dec(8'h21, 8'd1);
        wait_drain();
        add_up(8'h5C, 1);
        wait_drain();

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
